// File: rtl/rwt_dac_capture.sv
// rwt_dac_capture: DAC-side sample capture.
// Drives channel enables and a rate-divided read strobe towards a DAC core,
// stores each strobed dac_data frame in a frame FIFO and serialises the
// enabled channels onto a ready/valid word stream with m_last per frame.
// Optional feature macro: RWT_DAC_CAPTURE_OVF_CNT_EN builds the saturating
// dropped-frame counter; without it overflow_count is tied to zero.
//
// Handshake: a word transfers on every rising edge where m_valid && m_ready.
// While m_valid is high and m_ready low, m_data/m_chan/m_last hold and
// m_valid stays high; only reset can withdraw a pending word.
module rwt_dac_capture #(
   parameter int NUM_CHANNELS = 4,
   parameter int SAMPLE_WIDTH = 16,
   parameter int FIFO_DEPTH   = 16,
   parameter int CNT_WIDTH    = 32,
   parameter int DIV_WIDTH    = 16,
   localparam int CHAN_W      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                                 clk,
   input  logic                                 resetn,
   input  logic [NUM_CHANNELS-1:0]              cfg_enable_mask,
   input  logic [DIV_WIDTH-1:0]                 cfg_rate_div,
   input  logic [CNT_WIDTH-1:0]                 cfg_num_samples,
   input  logic                                 start,
   input  logic                                 stop,
   output logic [NUM_CHANNELS-1:0]              dac_enable,
   output logic                                 dac_valid,
   input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] dac_data,
   output logic [SAMPLE_WIDTH-1:0]              m_data,
   output logic [CHAN_W-1:0]                    m_chan,
   output logic                                 m_valid,
   input  logic                                 m_ready,
   output logic                                 m_last,
   output logic                                 busy,
   output logic [15:0]                          overflow_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int FW = NUM_CHANNELS * SAMPLE_WIDTH;
   localparam logic [AW:0] DEPTH_L = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

   state_t                  state_q, state_d;
   logic [NUM_CHANNELS-1:0] mask_q, mask_d;
   logic [DIV_WIDTH-1:0]    div_q, div_d, div_cnt_q, div_cnt_d;
   logic [CNT_WIDTH-1:0]    num_q, num_d, cnt_q, cnt_d;
   logic [NUM_CHANNELS-1:0] dac_enable_q, dac_enable_d;
   logic                    dac_valid_q, dac_valid_d;
   logic [FW-1:0]           mem_q [FIFO_DEPTH];
   logic [AW:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fill;
   logic                    fifo_full, pop, push, run_start;
   logic [SAMPLE_WIDTH-1:0] m_data_q, m_data_d;
   logic [CHAN_W-1:0]       m_chan_q, m_chan_d;
   logic                    m_last_q, m_last_d, m_valid_q, m_valid_d;
   logic [NUM_CHANNELS-1:0] rem_q, rem_d;
   logic [NUM_CHANNELS-1:0] src_mask, src_low;
   logic [FW-1:0]           src_frame;
   logic [CHAN_W-1:0]       src_idx;
   logic                    src_load;

   // Frame FIFO bookkeeping: the head frame is only popped once its last word
   // is accepted, so a same-cycle pop frees room for a push even when full.
   always_comb begin
      fill      = wr_ptr_q - rd_ptr_q;
      fifo_full = (fill == DEPTH_L);
      pop       = m_valid_q && m_ready && m_last_q;
      push      = dac_valid_q && (!fifo_full || pop);
      wr_ptr_d  = push ? wr_ptr_q + (AW + 1)'(1) : wr_ptr_q;
      rd_ptr_d  = pop  ? rd_ptr_q + (AW + 1)'(1) : rd_ptr_q;
      run_start = (state_q == ST_IDLE) && start && (cfg_enable_mask != '0);
   end

   // Control FSM: run configuration, sample counter, strobe divider, enables.
   always_comb begin
      state_d      = state_q;
      mask_d       = mask_q;
      div_d        = div_q;
      num_d        = num_q;
      cnt_d        = cnt_q;
      div_cnt_d    = div_cnt_q;
      dac_valid_d  = 1'b0;
      dac_enable_d = '0;
      case (state_q)
         ST_IDLE: begin
            if (run_start) begin
               state_d      = ST_RUN;
               mask_d       = cfg_enable_mask;
               div_d        = cfg_rate_div;
               num_d        = cfg_num_samples;
               cnt_d        = '0;
               div_cnt_d    = cfg_rate_div;
               dac_valid_d  = 1'b1;
               dac_enable_d = cfg_enable_mask;
            end
         end
         ST_RUN: begin
            if (dac_valid_q) cnt_d = cnt_q + CNT_WIDTH'(1);
            if (stop || (dac_valid_q && (num_q != '0) && (cnt_q + CNT_WIDTH'(1) == num_q))) begin
               state_d = ST_DRAIN;
            end else begin
               dac_enable_d = mask_q;
               if (div_cnt_q == '0) begin
                  dac_valid_d = 1'b1;
                  div_cnt_d   = div_q;
               end else begin
                  div_cnt_d   = div_cnt_q - DIV_WIDTH'(1);
               end
            end
         end
         ST_DRAIN: begin
            if ((fill == '0) && !m_valid_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Serialiser: pick the next word from the head frame (or the frame behind
   // it when the head's last word is leaving) so frames follow back to back.
   always_comb begin
      src_load  = 1'b0;
      src_mask  = mask_q;
      src_frame = mem_q[rd_ptr_q[AW-1:0]];
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_chan_d  = m_chan_q;
      m_last_d  = m_last_q;
      rem_d     = rem_q;
      if (!m_valid_q) begin
         src_load = (fill != '0);
      end else if (m_ready) begin
         if (!m_last_q) begin
            src_load = 1'b1;
            src_mask = rem_q;
         end else if (fill > (AW + 1)'(1)) begin
            src_load  = 1'b1;
            src_frame = mem_q[rd_ptr_d[AW-1:0]];
         end else begin
            m_valid_d = 1'b0;
         end
      end
      src_low = src_mask & (~src_mask + NUM_CHANNELS'(1));
      src_idx = '0;
      for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
         if (src_mask[i]) src_idx = CHAN_W'(i);
      end
      if (src_load) begin
         m_valid_d = 1'b1;
         m_chan_d  = src_idx;
         rem_d     = src_mask & ~src_low;
         m_last_d  = ((src_mask & ~src_low) == '0);
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (CHAN_W'(i) == src_idx) m_data_d = src_frame[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         mask_q       <= '0;
         div_q        <= '0;
         num_q        <= '0;
         cnt_q        <= '0;
         div_cnt_q    <= '0;
         dac_enable_q <= '0;
         dac_valid_q  <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         m_data_q     <= '0;
         m_chan_q     <= '0;
         m_last_q     <= 1'b0;
         m_valid_q    <= 1'b0;
         rem_q        <= '0;
      end else begin
         state_q      <= state_d;
         mask_q       <= mask_d;
         div_q        <= div_d;
         num_q        <= num_d;
         cnt_q        <= cnt_d;
         div_cnt_q    <= div_cnt_d;
         dac_enable_q <= dac_enable_d;
         dac_valid_q  <= dac_valid_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         m_data_q     <= m_data_d;
         m_chan_q     <= m_chan_d;
         m_last_q     <= m_last_d;
         m_valid_q    <= m_valid_d;
         rem_q        <= rem_d;
      end
   end

   // Frame storage; contents are don't-care once the pointers are reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= dac_data;
   end

`ifdef RWT_DAC_CAPTURE_OVF_CNT_EN
   logic [15:0] ovf_q, ovf_d;
   logic        drop;

   // Dropped-frame counter: cleared on run start, saturates at all ones.
   always_comb begin
      drop  = dac_valid_q && fifo_full && !pop;
      ovf_d = ovf_q;
      if (run_start) ovf_d = '0;
      else if (drop && (ovf_q != 16'hFFFF)) ovf_d = ovf_q + 16'd1;
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (!resetn) ovf_q <= '0;
      else         ovf_q <= ovf_d;
   end

   assign overflow_count = ovf_q;
`else
   assign overflow_count = '0;
`endif

   assign dac_enable = dac_enable_q;
   assign dac_valid  = dac_valid_q;
   assign m_data     = m_data_q;
   assign m_chan     = m_chan_q;
   assign m_last     = m_last_q;
   assign m_valid    = m_valid_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rwt_dac_capture.sv
// tb_rwt_dac_capture: scoreboard bench for rwt_dac_capture (4 channels,
// 16-bit samples, 16-deep frame FIFO). Inputs change 1-2 ns after the rising
// edge; outputs are observed on the falling edge.
module tb_rwt_dac_capture;
  localparam int NC = 4;
  localparam int SW = 16;
  localparam int DEPTH = 16;
  localparam int EW = 2 + 1 + SW;
`ifdef RWT_DAC_CAPTURE_OVF_CNT_EN
  localparam int OVF_EXP = 4;
`else
  localparam int OVF_EXP = 0;
`endif

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [NC-1:0]     cfg_enable_mask = '0;
  logic [15:0]       cfg_rate_div = '0;
  logic [31:0]       cfg_num_samples = '0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [NC-1:0]     dac_enable;
  logic              dac_valid;
  logic [NC*SW-1:0]  dac_data = '0;
  logic [SW-1:0]     m_data;
  logic [1:0]        m_chan;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic              m_last;
  logic              busy;
  logic [15:0]       overflow_count;

  rwt_dac_capture dut (
    .clk(clk), .resetn(resetn), .cfg_enable_mask(cfg_enable_mask),
    .cfg_rate_div(cfg_rate_div), .cfg_num_samples(cfg_num_samples),
    .start(start), .stop(stop), .dac_enable(dac_enable), .dac_valid(dac_valid),
    .dac_data(dac_data), .m_data(m_data), .m_chan(m_chan), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .overflow_count(overflow_count)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [EW-1:0] exp_q[$];
  int strobe_cnt, words, first_strobe, last_strobe, first_word, model_cnt, frame_idx;
  logic [NC-1:0] cur_mask = '0;
  logic toggle_en = 1'b0;
  logic prev_stall = 1'b0;
  logic [EW-1:0] prev_word = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] smp(input int f, input int ch);
    logic [31:0] v;
    v = 32'(f) * 32'h1000 + 32'(ch);
    return v[SW-1:0];
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    strobe_cnt = 0; words = 0; first_strobe = -1; last_strobe = -1;
    first_word = -1; model_cnt = 0; frame_idx = 0;
  endtask

  always @(posedge clk) cyc++;

  // DAC core model: present frame frame_idx, channel i = 0x1000*frame + i
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NC; i++) dac_data[i*SW +: SW] = smp(frame_idx, i);
    if (toggle_en) m_ready = ~m_ready;
  end

  // scoreboard: expected words pushed on each strobe, popped on each handshake
  always @(negedge clk) begin
    logic [EW-1:0] w, e;
    int hi;
    logic pop_now;
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      w = {m_chan, m_last, m_data};
      if (dac_valid) begin
        if (first_strobe < 0) first_strobe = cyc;
        last_strobe = cyc;
        pop_now = m_valid && m_ready && m_last;
        if (model_cnt < DEPTH || pop_now) begin
          hi = 0;
          for (int i = 0; i < NC; i++) if (cur_mask[i]) hi = i;
          for (int i = 0; i < NC; i++)
            if (cur_mask[i]) exp_q.push_back({2'(i), (i == hi), smp(frame_idx, i)});
          model_cnt++;
        end
        strobe_cnt++;
        frame_idx++;
      end
      if (prev_stall) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_word", 32'(w), 32'(prev_word));
      end
      if (m_valid && first_word < 0) first_word = cyc;
      if (m_valid && m_ready) begin
        words++;
        if (exp_q.size() == 0) begin
          chk("sb_size_on_word", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("word", 32'(w), 32'(e));
        end
        if (m_last) model_cnt--;
      end
      prev_stall = m_valid && !m_ready;
      prev_word = w;
    end
  end

  // driver tasks
  task automatic start_run(input logic [NC-1:0] mask, input int div, input int num);
    cfg_enable_mask = mask;
    cfg_rate_div = 16'(div);
    cfg_num_samples = 32'(num);
    cur_mask = mask;
    clear_sb();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_enable", 32'(dac_enable), 32'(mask));
    chk("start_valid", 32'(dac_valid), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_outs"}, 32'({dac_enable, dac_valid, m_data, m_chan, m_valid, m_last, busy}), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow_count), 32'd0);
  endtask

  initial begin
    clear_sb();
    step(3);
    check_reset_outputs("reset");
    resetn = 1'b1;
    step();

    // bounded masked run
    m_ready = 1'b1;
    start_run(4'b0101, 0, 3);
    wait_idle("t1_idle", 100);
    chk("t1_strobes", 32'(strobe_cnt), 32'd3);
    chk("t1_words", 32'(words), 32'd6);
    chk("t1_sb_left", 32'(exp_q.size()), 32'd0);
    chk("t1_latency", 32'(first_word - first_strobe), 32'd2);

    // divider
    start_run(4'b1111, 3, 4);
    wait_idle("t2_idle", 200);
    chk("t2_strobes", 32'(strobe_cnt), 32'd4);
    chk("t2_span", 32'(last_strobe - first_strobe), 32'd12);
    chk("t2_latency", 32'(first_word - first_strobe), 32'd2);
    chk("t2_words", 32'(words), 32'd16);
    chk("t2_sb_left", 32'(exp_q.size()), 32'd0);

    // overflow with ready held low
    m_ready = 1'b0;
    start_run(4'b0001, 0, 20);
    for (int n = 0; n < 60 && strobe_cnt < 20; n++) step();
    step(3);
    chk("t3_strobes", 32'(strobe_cnt), 32'd20);
    chk("t3_ovf", 32'(overflow_count), 32'(OVF_EXP));
    chk("t3_busy_held", 32'(busy), 32'd1);
    m_ready = 1'b1;
    wait_idle("t3_idle", 100);
    chk("t3_words", 32'(words), 32'd16);
    chk("t3_sb_left", 32'(exp_q.size()), 32'd0);

    // stop coincident with 5th strobe, ready toggling
    toggle_en = 1'b1;
    start_run(4'b1011, 0, 0);
    step(4);
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_idle("t4_idle", 200);
    toggle_en = 1'b0;
    chk("t4_strobes", 32'(strobe_cnt), 32'd5);
    chk("t4_words", 32'(words), 32'd15);
    chk("t4_sb_left", 32'(exp_q.size()), 32'd0);

    // reset mid-drain with 8 frames queued
    step();
    m_ready = 1'b0;
    start_run(4'b0001, 0, 8);
    step(14);
    chk("t5_busy_before", 32'(busy), 32'd1);
    chk("t5_valid_before", 32'(m_valid), 32'd1);
    resetn = 1'b0;
    step();
    check_reset_outputs("t5_reset");
    clear_sb();
    resetn = 1'b1;
    m_ready = 1'b1;
    step(10);
    chk("t5_words_after", 32'(words), 32'd0);
    chk("t5_busy_after", 32'(busy), 32'd0);

    // ignored pulses
    cfg_enable_mask = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_zero_mask_busy", 32'(busy), 32'd0);
    chk("t6_zero_mask_en", 32'(dac_enable), 32'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t6_idle_stop_busy", 32'(busy), 32'd0);
    start_run(4'b0011, 1, 6);
    step(3);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle("t6_idle", 200);
    chk("t6_strobes", 32'(strobe_cnt), 32'd6);
    chk("t6_words", 32'(words), 32'd12);
    chk("t6_sb_left", 32'(exp_q.size()), 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
